// File: rtl/guess_judge.sv
// rtl/guess_judge.sv - number-guessing game front end: key debounce, secret LFSR, guess compare
//
// Purpose: synchronizes and debounces the active-low submit key, emits one
// guess_pulse per accepted press, holds a secret loaded from a free-running
// LFSR and reports whether each accepted guess is too high, too low or correct.
// Once the player wins, further presses are ignored until new_game.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   key_n        raw submit pushbutton, active-low, asynchronous to clk
//   new_game     single-cycle request to start a new game
//   guess        player guess, sampled on the accept cycle
//   guess_pulse  one-cycle strobe per accepted submission (feeds the guess counter)
//   too_high     last accepted guess > secret
//   too_low      last accepted guess < secret
//   correct      last accepted guess == secret; held while won
//   secret       current secret, for debug LEDs
module guess_judge #(
  parameter int         W               = 8,
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter logic [7:0] SEED            = 8'h5A
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_n,
  input  logic         new_game,
  input  logic [W-1:0] guess,
  output logic         guess_pulse,
  output logic         too_high,
  output logic         too_low,
  output logic         correct,
  output logic [W-1:0] secret
);

  // The counter only has to reach DEBOUNCE_CYCLES-1; the acceptance happens on
  // the sample that would take it to DEBOUNCE_CYCLES.
  localparam int             CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_PLAY = 2'd1,
    S_WON  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    lfsr;
  logic          sync1, sync2;
  logic          deb, deb_d;
  logic [CW-1:0] cnt;
  logic          press;

  logic [W-1:0]  secret_nxt;
  logic          too_high_nxt, too_low_nxt, correct_nxt, pulse_nxt;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; from a nonzero seed it never reaches 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Two-flop synchronizer; idles at 1 (released).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Debouncer: the debounced level only follows the synchronized key after
  // DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb   <= 1'b1;
      deb_d <= 1'b1;
      cnt   <= '0;
    end else begin
      deb_d <= deb;
      if (sync2 != deb) begin
        if (cnt == LAST) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // A press is the 1->0 edge of the debounced level, seen one cycle after it.
  assign press = deb_d & ~deb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_LOAD;
      secret      <= '0;
      too_high    <= 1'b0;
      too_low     <= 1'b0;
      correct     <= 1'b0;
      guess_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      secret      <= secret_nxt;
      too_high    <= too_high_nxt;
      too_low     <= too_low_nxt;
      correct     <= correct_nxt;
      guess_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    secret_nxt   = secret;
    too_high_nxt = too_high;
    too_low_nxt  = too_low;
    correct_nxt  = correct;
    pulse_nxt    = 1'b0;

    // new_game wins over everything, including a press on the same edge,
    // which is dropped.
    if (new_game || state == S_LOAD) begin
      secret_nxt   = W'(lfsr);
      too_high_nxt = 1'b0;
      too_low_nxt  = 1'b0;
      correct_nxt  = 1'b0;
      state_nxt    = S_PLAY;
    end else if (state == S_PLAY && press) begin
      pulse_nxt    = 1'b1;
      too_high_nxt = (guess > secret);
      too_low_nxt  = (guess < secret);
      correct_nxt  = (guess == secret);
      if (guess == secret) begin
        state_nxt = S_WON;
      end
    end
  end

endmodule

// File: tb/tb_guess_judge.sv
// tb/tb_guess_judge.sv - scoreboard bench for guess_judge with behavioural model
module tb_guess_judge;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic       new_game;
  logic [7:0] guess;
  logic       guess_pulse;
  logic       too_high;
  logic       too_low;
  logic       correct;
  logic [7:0] secret;

  guess_judge #(
    .W              (8),
    .DEBOUNCE_CYCLES(D),
    .SEED           (8'h5A)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .new_game   (new_game),
    .guess      (guess),
    .guess_pulse(guess_pulse),
    .too_high   (too_high),
    .too_low    (too_low),
    .correct    (correct),
    .secret     (secret)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int   cyc;
    logic hi;
    logic lo;
    logic cor;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  // Reference model state
  int         cyc;
  logic [2:0] m_keys;      // key_n as seen at the last edges; oldest is what the filter sees
  logic       m_lvl;
  int         m_run;
  logic       m_fell;
  logic       m_press;
  logic       m_samp;
  logic [7:0] m_lfsr;
  logic [7:0] m_secret;
  logic       m_hi, m_lo, m_cor;
  int         m_phase;     // 0 load, 1 play, 2 won

  int pulse_cnt      = 0;
  int last_pulse_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: key level must hold for D consecutive synchronized samples before the
  // filtered level moves; a filtered fall is acted on one edge later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc      = 0;
      m_keys   = 3'b111;
      m_lvl    = 1'b1;
      m_run    = 0;
      m_fell   = 1'b0;
      m_lfsr   = 8'h5A;
      m_secret = 8'h00;
      m_hi     = 1'b0;
      m_lo     = 1'b0;
      m_cor    = 1'b0;
      m_phase  = 0;
      sbq.delete();
    end else begin
      cyc++;
      m_samp  = m_keys[1];
      m_keys  = {m_keys[1:0], key_n};
      m_press = m_fell;
      m_fell  = 1'b0;
      if (m_samp != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_lvl  = m_samp;
          m_run  = 0;
          m_fell = (m_samp == 1'b0);
        end
      end else begin
        m_run = 0;
      end
      if (new_game || m_phase == 0) begin
        m_secret = m_lfsr;
        m_hi = 1'b0; m_lo = 1'b0; m_cor = 1'b0;
        m_phase = 1;
      end else if (m_phase == 1 && m_press) begin
        m_hi  = (int'(guess) > int'(m_secret));
        m_lo  = (int'(guess) < int'(m_secret));
        m_cor = (guess == m_secret);
        sbq.push_back('{cyc, m_hi, m_lo, m_cor});
        if (m_cor) m_phase = 2;
      end
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  // Monitor: pops an expectation whenever the DUT strobes guess_pulse.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (guess_pulse === 1'b1) begin
        pulse_cnt++;
        last_pulse_cyc = cyc;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = sbq.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_flags", {too_high, too_low, correct}, {e.hi, e.lo, e.cor});
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missed_pulse: got none expected pulse at cycle %0d", sbq[0].cyc);
        void'(sbq.pop_front());
      end
      check("secret", secret, m_secret);
      check("flags", {too_high, too_low, correct}, {m_hi, m_lo, m_cor});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // key_n low for lo_n cycles then high for hi_n; new_game pulsed at index ng_at.
  task automatic drive(input int lo_n, input int hi_n, input int ng_at);
    for (int i = 0; i < lo_n + hi_n; i++) begin
      key_n    = (i >= lo_n);
      new_game = (i == ng_at);
      @(negedge clk);
    end
    new_game = 1'b0;
  endtask

  int p0, k0;

  initial begin
    reset = 1'b1; key_n = 1'b1; new_game = 1'b0; guess = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("reset_secret", secret, 8'h00);
    check("reset_flags", {guess_pulse, too_high, too_low, correct}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    p0 = pulse_cnt;
    repeat (3) @(negedge clk);
    check("idle_secret_seed", secret, 8'h5A);
    check("idle_no_pulse", pulse_cnt - p0, 0);

    // Held press: one pulse at edge D+3, too_low, none on release.
    guess = 8'h10;
    p0 = pulse_cnt; k0 = cyc;
    drive(20, 12, -1);
    check("held_one_pulse", pulse_cnt - p0, 1);
    check("held_pulse_edge", last_pulse_cyc - k0, D + 3);
    check("held_too_low", {too_high, too_low, correct}, 3'b010);

    // Bounce shorter than D is filtered; a clean press then gives too_high.
    guess = 8'hA0;
    p0 = pulse_cnt;
    drive(D - 1, 12, -1);
    check("glitch_no_pulse", pulse_cnt - p0, 0);
    check("glitch_flags_held", {too_high, too_low, correct}, 3'b010);
    drive(10, 10, -1);
    check("clean_pulse", pulse_cnt - p0, 1);
    check("clean_too_high", {too_high, too_low, correct}, 3'b100);

    // Win, then presses are locked out.
    guess = 8'h5A;
    p0 = pulse_cnt;
    drive(10, 10, -1);
    check("win_pulse", pulse_cnt - p0, 1);
    check("win_correct", {too_high, too_low, correct}, 3'b001);
    guess = 8'h00;
    p0 = pulse_cnt;
    drive(10, 10, -1);
    drive(10, 10, -1);
    check("won_no_pulse", pulse_cnt - p0, 0);
    check("won_correct_held", correct, 1'b1);

    // new_game from WON, then presses count again.
    drive(0, 2, 0);
    check("newgame_flags", {too_high, too_low, correct}, 3'b000);
    check("newgame_secret", secret, m_secret);
    guess = $urandom;
    p0 = pulse_cnt;
    drive(10, 10, -1);
    check("newgame_press", pulse_cnt - p0, 1);

    // new_game on the edge where the press would be accepted: press dropped.
    guess = $urandom;
    p0 = pulse_cnt;
    drive(15, 10, D + 2);
    check("coincide_no_pulse", pulse_cnt - p0, 0);
    check("coincide_flags", {too_high, too_low, correct}, 3'b000);

    // Randomized play with occasional new_game and short bounces.
    for (int it = 0; it < 40; it++) begin
      guess = ($urandom_range(0, 3) == 0) ? m_secret : 8'($urandom);
      drive($urandom_range(1, 9), $urandom_range(1, 9),
            ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1);
    end
    drive(0, 12, -1);

    // Reset while the key is held mid-debounce.
    guess = 8'h33;
    key_n = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_secret", secret, 8'h00);
    check("midreset_flags", {guess_pulse, too_high, too_low, correct}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    p0 = pulse_cnt; k0 = cyc;
    repeat (15) @(negedge clk);
    check("midreset_one_pulse", pulse_cnt - p0, 1);
    check("midreset_pulse_edge", last_pulse_cyc - k0, D + 3);
    drive(0, 12, -1);

    check("queue_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/guess_judge.md
Name: guess_judge

Overview:
- Front end of the number-guessing game datapath, directly upstream of the guess counter/display stage.
- Synchronizes and debounces the active-low submit key, then emits a single-cycle `guess_pulse` per accepted press; `guess_pulse` drives the counter's `in`.
- Holds the secret number, which is loaded from a free-running LFSR.
- Compares each submitted guess against the secret and drives the too-high / too-low / correct indicators.
- Locks out further submissions once the player wins, until a new game starts.

Parameters:
- W, 8, width of guess and secret.
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples required to accept a key level change (minimum 1).
- SEED, 8'h5A, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- key_n  input  1  raw submit pushbutton, active-low, asynchronous to clk.
- new_game  input  1  synchronous single-cycle request to start a new game.
- guess  input  W  player guess from switches, sampled on the accept cycle.
- guess_pulse  output  1  one-cycle strobe per accepted submission; feeds the guess counter.
- too_high  output  1  last accepted guess > secret.
- too_low  output  1  last accepted guess < secret.
- correct  output  1  last accepted guess == secret; stays high while in WON.
- secret  output  W  current secret, exposed for debug LEDs.

Behaviour:
- **Reset (async).**
  - lfsr=SEED, secret=0, state=LOAD.
  - All flag outputs 0, guess_pulse=0.
  - Sync flops=1, debounced level=1 (released), debounce count=0.
- **LFSR.**
  - W=8, Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts left every clock; the feedback bit enters at bit 0.
  - Never reaches 0.
- **Synchronizer.** 2-flop chain on key_n.
- **Debouncer.**
  - When the synchronized level differs from the debounced level, the counter increments.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - Any sample equal to the debounced level clears the counter.
  - A press is a 1->0 transition of the debounced level.
- **Latency.**
  - key_n held low from before clock edge 1: sync2 is low after edge 2, and the debounced level falls at edge DEBOUNCE_CYCLES+2.
  - guess_pulse is registered high for the cycle following edge DEBOUNCE_CYCLES+3, and low at the next edge.
  - Release requires no pulse; the debounced level returns to 1 after the same filtering.
  - Holding the key produces exactly one pulse.
  - A bounce shorter than DEBOUNCE_CYCLES produces no pulse.
- **States.**
  - LOAD: at the next edge, secret<=lfsr, flags cleared, go PLAY. After reset the first secret is therefore SEED.
  - PLAY: on a press, guess_pulse<=1 and guess is compared unsigned with secret:
    - guess > secret: too_high<=1, other flags 0.
    - guess < secret: too_low<=1, other flags 0.
    - guess == secret: correct<=1, others 0, go WON.
    - Flags update on the same edge as guess_pulse rises and hold until the next press or new game.
  - WON: presses are ignored (no pulse, flags unchanged); correct stays 1.
- **new_game.**
  - In any state, new_game=1 means that at the edge, secret<=current lfsr, flags<=0, and the next state is PLAY. No LOAD cycle is needed.
  - new_game has priority over a simultaneous press: no pulse, no compare.
- **Pending press across new_game.**
  - A press whose debounced fall coincides with new_game is consumed (dropped).
  - Debouncer state is not affected by new_game.
- **guess width.** guess must be stable across the accept edge; no further synchronization is applied (switches are quasi-static).
- **Counter interface.**
  - guess_pulse is high for exactly one clk period, so the downstream counter sees one rising edge per accepted guess.
  - Counter reset is driven externally and is not controlled here.

Test Plan (DEBOUNCE_CYCLES=4, SEED=8'h5A):
- Reset, then idle 2 cycles -> secret=8'h5A, all flags 0, guess_pulse never high.
- guess=8'h10, key_n low held 20 cycles from edge 1 -> exactly one guess_pulse, high after edge 7; too_low=1, too_high=0, correct=0; no pulse on release.
- guess=8'hA0, key_n glitches low 3 cycles then high -> no pulse, flags unchanged. Then a clean press -> one pulse, too_high=1.
- guess=8'h5A, clean press -> pulse, correct=1, state WON. Two further clean presses with guess=8'h00 -> no pulses, correct stays 1.
- From WON, new_game pulse -> next cycle secret equals the LFSR value at that edge (checked against a reference model), flags 0. A press now yields a pulse again.
- Press timed so the debounced fall coincides with new_game -> no pulse, flags 0, secret reloaded. Separately, assert reset while key_n is held low mid-debounce -> immediate reset values; after reset release with key still low, exactly one pulse follows DEBOUNCE_CYCLES+3 edges later.
